// File: rtl/uart_rx_buffer.sv
// Purpose : captures UART receiver characters {parity_error, data} into a FWFT FIFO
//           and acknowledges each one so the receiver is released for the next frame.
// Latency : entry written and count updated on the capture edge; rx_ack_o one cycle later;
//           head visible on rd_data_o one cycle after the write edge into an empty FIFO.
// Backpressure: none toward the receiver; a character arriving at full (without a same-cycle
//           pop) is dropped, acknowledged anyway, and flagged on sticky overrun_o.
// Ports   : clk/rst_n (async active-low); rx_done_i/rx_data_i/parity_error_i/rx_ack_o from/to
//           the receiver; pop_i/flush_i/thresh_i/overrun_clr_i from the host; rd_data_o,
//           rd_perr_o, count_o, empty_o, full_o, overrun_o, irq_o status to the host.
module uart_rx_buffer #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_done_i,
    input  logic [7:0]    rx_data_i,
    input  logic          parity_error_i,
    output logic          rx_ack_o,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [AW:0]   thresh_i,
    input  logic          overrun_clr_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_perr_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overrun_o,
    output logic          irq_o
);

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_ACK,
        CAP_WAIT
    } cap_state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic              w_push_try;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_empty;
    logic              w_full;
    logic [8:0]        w_head;

    logic [8:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overrun;

    // ---------------- capture FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push_try  = 1'b0;
        case (r_state)
            CAP_IDLE: begin
                if (rx_done_i) begin
                    w_push_try  = 1'b1;
                    w_state_nxt = CAP_ACK;
                end
            end
            // Ack is sent even for a dropped character so the receiver never stalls.
            CAP_ACK:  w_state_nxt = CAP_WAIT;
            // Hold off until the receiver releases done, so one character = one push.
            CAP_WAIT: begin
                if (!rx_done_i) begin
                    w_state_nxt = CAP_IDLE;
                end
            end
            default:  w_state_nxt = CAP_IDLE;
        endcase
    end

    // Decoded straight from the state register, so it is glitch-free and drops at reset.
    assign rx_ack_o = (r_state == CAP_ACK);

    // ---------------- FIFO control ----------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // At full a same-cycle pop frees the slot being written, so the push still lands.
    assign w_push = w_push_try && (!w_full || pop_i);
    assign w_drop = w_push_try && w_full && !pop_i;
    // A pop with a simultaneous push at empty consumes the new entry: count stays 0 and the
    // host sees the forced-zero read value, not a bypass of the pushed character.
    assign w_pop  = pop_i && (!w_empty || w_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left unreset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= {parity_error_i, rx_data_i};
        end
    end

    // Set has priority over clear so a drop in the clear cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign w_head    = r_mem[r_rd_ptr];
    assign rd_data_o = w_empty ? 8'h00 : w_head[7:0];
    assign rd_perr_o = w_empty ? 1'b0  : w_head[8];
    assign count_o   = r_count;
    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign overrun_o = r_overrun;
    assign irq_o     = (thresh_i != '0) && (r_count >= thresh_i);

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Purpose : self-checking bench for uart_rx_buffer (DEPTH=16) with a queue-based scoreboard.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on falling edge.
// Backpressure: the bench acts as both receiver and host; acks are counted by the monitor.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_done_i;
    logic [7:0]    rx_data_i;
    logic          parity_error_i;
    logic          rx_ack_o;
    logic          pop_i;
    logic          flush_i;
    logic [AW:0]   thresh_i;
    logic          overrun_clr_i;
    logic [7:0]    rd_data_o;
    logic          rd_perr_o;
    logic [AW:0]   count_o;
    logic          empty_o;
    logic          full_o;
    logic          overrun_o;
    logic          irq_o;

    int            checks = 0;
    int            errors = 0;
    int            ack_cnt = 0;
    int            a0;
    logic [8:0]    exp_q [$];

    always #5 clk = ~clk;

    uart_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_done_i      (rx_done_i),
        .rx_data_i      (rx_data_i),
        .parity_error_i (parity_error_i),
        .rx_ack_o       (rx_ack_o),
        .pop_i          (pop_i),
        .flush_i        (flush_i),
        .thresh_i       (thresh_i),
        .overrun_clr_i  (overrun_clr_i),
        .rd_data_o      (rd_data_o),
        .rd_perr_o      (rd_perr_o),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .overrun_o      (overrun_o),
        .irq_o          (irq_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Receiver model: raise done with the character, wait for ack, drop done after
    // 'hold' extra cycles, then allow the FSM to return to idle.
    task automatic send_char(input logic [7:0] d, input logic pe, input int hold,
                             input logic with_pop, input logic exp_acc);
        int n;
        @(posedge clk); #1;
        rx_done_i      = 1'b1;
        rx_data_i      = d;
        parity_error_i = pe;
        if (with_pop) pop_i = 1'b1;
        if (exp_acc) exp_q.push_back({pe, d});
        @(posedge clk); #1;
        pop_i = 1'b0;
        n = 0;
        while (!rx_ack_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 8) chk("ack_timeout", 32'(n), 0);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        rx_done_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_pop();
        @(posedge clk); #1;
        pop_i = 1'b1;
        @(posedge clk); #1;
        pop_i = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_done_i = 1'b0; rx_data_i = 8'h00; parity_error_i = 1'b0;
        pop_i = 1'b0; flush_i = 1'b0; thresh_i = '0; overrun_clr_i = 1'b0;

        // Monitor: counts acks and checks every effective host pop against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (rx_ack_o) ack_cnt++;
                if (rst_n && pop_i && !empty_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pop_data", {23'd0, rd_perr_o, rd_data_o}, 32'h1FF);
                    end else begin
                        logic [8:0] e;
                        e = exp_q.pop_front();
                        chk("pop_data", {23'd0, rd_perr_o, rd_data_o}, {23'd0, e});
                    end
                end
            end
        join_none

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_ack", rx_ack_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rd", {rd_perr_o, rd_data_o}, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // ---- single character ----
        a0 = ack_cnt;
        send_char(8'h5A, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("single_acks", 32'(ack_cnt - a0), 1);
        chk("single_count", count_o, 1);
        chk("single_rd_data", rd_data_o, 8'h5A);
        chk("single_rd_perr", rd_perr_o, 0);
        do_pop();
        @(negedge clk);
        chk("single_empty", empty_o, 1);
        chk("single_rd_zero", rd_data_o, 0);

        // ---- threshold, fill, overrun ----
        thresh_i = 5'd4;
        a0 = ack_cnt;
        for (int i = 0; i < 3; i++) send_char(8'(i), 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("irq_below", irq_o, 0);
        send_char(8'h03, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("irq_at", irq_o, 1);
        for (int i = 4; i < 16; i++) send_char(8'(i), 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fill_full", full_o, 1);
        chk("fill_overrun0", overrun_o, 0);
        send_char(8'hAA, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_acks", 32'(ack_cnt - a0), 17);
        chk("drop_overrun", overrun_o, 1);
        chk("drop_count", count_o, 16);
        thresh_i = 5'd0;
        @(negedge clk);
        chk("irq_disabled_full", irq_o, 0);

        // ---- clear overrun, push at full with same-cycle pop ----
        @(posedge clk); #1; overrun_clr_i = 1'b1;
        @(posedge clk); #1; overrun_clr_i = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", overrun_o, 0);
        send_char(8'h77, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("fullpop_overrun", overrun_o, 0);
        chk("fullpop_count", count_o, 16);
        for (int i = 0; i < 16; i++) do_pop();
        @(negedge clk);
        chk("drain_empty", empty_o, 1);
        chk("drain_sb_empty", 32'(exp_q.size()), 0);

        // ---- flush keeps overrun ----
        for (int i = 0; i < 16; i++) send_char(8'h30 + 8'(i), 1'b1, 0, 1'b0, 1'b1);
        send_char(8'hBB, 1'b0, 0, 1'b0, 1'b0);
        thresh_i = 5'd4;
        @(negedge clk);
        chk("refill_overrun", overrun_o, 1);
        chk("refill_irq", irq_o, 1);
        do_flush();
        @(negedge clk);
        chk("flush_count", count_o, 0);
        chk("flush_irq", irq_o, 0);
        chk("flush_overrun_kept", overrun_o, 1);
        chk("flush_rd_zero", {rd_perr_o, rd_data_o}, 0);

        // ---- long done, 5-bit character with parity error ----
        a0 = ack_cnt;
        send_char(8'h1F, 1'b1, 10, 1'b0, 1'b1);
        @(negedge clk);
        chk("hold_acks", 32'(ack_cnt - a0), 1);
        chk("hold_count", count_o, 1);
        chk("hold_rd_data", rd_data_o, 8'h1F);
        chk("hold_rd_perr", rd_perr_o, 1);
        do_pop();

        // ---- pointer wrap via interleaved push/pop ----
        for (int i = 0; i < 40; i++) begin
            send_char(8'h80 + 8'(i), 1'(i % 3 == 0), 0, 1'(i > 0), 1'b1);
        end
        @(negedge clk);
        chk("wrap_count", count_o, 1);
        do_pop();
        @(negedge clk);
        chk("wrap_sb_empty", 32'(exp_q.size()), 0);
        do_pop();
        @(negedge clk);
        chk("pop_empty_count", count_o, 0);
        chk("pop_empty_flag", empty_o, 1);

        // ---- reset during the ack cycle ----
        @(posedge clk); #1;
        rx_done_i = 1'b1; rx_data_i = 8'h42; parity_error_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_ack", rx_ack_o, 1);
        chk("pre_rst_count", count_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", rx_ack_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_overrun", overrun_o, 0);
        chk("mid_rst_rd", {rd_perr_o, rd_data_o}, 0);
        exp_q.delete();
        rx_done_i = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_irq", irq_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer placed directly downstream of the UART receiver and upstream of the APB register file. It captures each completed character (data plus parity-error flag) from the receiver's level-held done flag and returns a one-cycle acknowledge that releases the receiver for the next frame. Characters are queued in a first-word-fall-through FIFO for the host. The block also provides occupancy, overrun and threshold-interrupt status.

## Interface

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥ 2. AW = log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_done_i  in  1  receiver character-ready level; held high until acknowledged
- rx_data_i  in  8  receiver data, zero-extended for 5/6/7-bit frames
- parity_error_i  in  1  receiver parity error for the current character
- rx_ack_o  out  1  one-cycle pulse to the receiver's host-read input
- pop_i  in  1  host read of data register; removes head entry
- flush_i  in  1  synchronous FIFO clear
- thresh_i  in  AW+1  interrupt threshold; 0 disables the interrupt
- overrun_clr_i  in  1  clears sticky overrun
- rd_data_o  out  8  head entry data
- rd_perr_o  out  1  head entry parity error
- count_o  out  AW+1  current occupancy, 0..DEPTH
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH
- overrun_o  out  1  sticky: a character was dropped
- irq_o  out  1  thresh_i != 0 and count_o >= thresh_i

## Operation

Storage:
- Each entry is 9 bits: {parity_error, data[7:0]}.
- Read and write pointers are AW bits and wrap modulo DEPTH. The count register is AW+1 bits.
- FWFT: rd_data_o and rd_perr_o show the head entry combinationally. When empty they are forced to 0.

Capture FSM, states CAP_IDLE, CAP_ACK, CAP_WAIT:
- CAP_IDLE, rx_done_i = 1:
  - Attempt a push of {parity_error_i, rx_data_i}, then go to CAP_ACK.
  - The push is accepted if !full_o, or if full_o and pop_i in the same cycle.
  - Otherwise the character is dropped and overrun_o is set.
- CAP_ACK:
  - rx_ack_o = 1 for exactly this cycle (registered output).
  - Always go to CAP_WAIT. The acknowledge is sent even on a drop, so the receiver never stalls.
- CAP_WAIT:
  - Stay until rx_done_i = 0, then go to CAP_IDLE.
  - This guarantees one push per character even if the receiver deasserts late.

Pop:
- pop_i with !empty_o advances the read pointer.
- pop_i when empty is ignored: no pointer or count change.

Simultaneous push and pop:
- Count is unchanged; both pointers advance.
- Also valid at full (entry replaced, no overrun) and at empty (count stays 0; the pushed entry is not bypassed to the popped value).

Flush:
- flush_i zeroes both pointers and the count.
- A same-cycle push or pop is discarded.
- The FSM is unaffected, so an in-progress acknowledge still completes.
- overrun_o is not cleared by flush.

Overrun:
- overrun_o is set on a drop and cleared by overrun_clr_i.
- If a set and a clear occur in the same cycle, the set wins.

## Timing

- Reset values:
  - FSM = CAP_IDLE; pointers and count = 0.
  - rx_ack_o = 0, overrun_o = 0, empty_o = 1, full_o = 0, irq_o = 0.
  - rd_data_o = 0, rd_perr_o = 0.
  - FIFO memory is not reset.
- rx_done_i rising sampled at edge N:
  - Entry written and count_o updated after edge N.
  - rx_ack_o high in cycle N+1.
  - The receiver drops rx_done_i after edge N+1; the FSM returns to CAP_IDLE after edge N+2 at the earliest.
  - Minimum spacing of 3 cycles between captures.
- Visibility: a pushed entry appears on rd_data_o one cycle after the write edge when the FIFO was empty.
- Status outputs: empty_o, full_o and irq_o are combinational from count_o; overrun_o is registered.
- Reset mid-operation: everything returns to reset values immediately; a pending acknowledge is lost.

## Test plan

- Single character: rx_done_i=1 with data 0x5A, perr 0 → exactly one rx_ack_o pulse; count_o=1; rd_data_o=0x5A, rd_perr_o=0; pop_i → empty_o=1, rd_data_o=0.
- Fill DEPTH=16 with 0x00..0x0F, then a 17th character 0xAA → full_o=1, overrun_o=1, still acked; pop order 0x00..0x0F; 0xAA never appears.
- At full, pop_i in the same cycle as capture of 0x77 → overrun_o stays 0, count_o stays 16, 0x77 becomes the last entry.
- rx_done_i held high 10 cycles → single push, single ack; 5-bit character 0x1F with perr 1 → rd_data_o=0x1F, rd_perr_o=1.
- thresh_i=4: push 3 → irq_o=0; push 4th → irq_o=1; flush_i → count_o=0, irq_o=0, overrun_o unchanged; thresh_i=0 → irq_o=0 at any count.
- Pointer wrap: 40 interleaved push/pop cycles → data order preserved; pop on empty → no change; assert rst_n=0 during CAP_ACK → rx_ack_o=0 at once and all outputs at reset values.
